// File: rtl/posit_unpack_pkg.sv
// Shared types and constants for posit field extraction and normalisation.
package posit_unpack_pkg;

  localparam int unsigned FIELD_W = 8;
  localparam int unsigned CNT_W   = 4;

  // Regime code marking zero/NaR, shared with the normalisation stage
  localparam logic [FIELD_W-1:0] POSIT_SPECIAL_REGIME = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic                      sign;
    logic signed [FIELD_W-1:0] regime;
    logic signed [FIELD_W-1:0] exponent;
    logic        [FIELD_W-1:0] mantissa;
    logic                      is_zero;
    logic                      is_nar;
  } posit_fields_t;

endpackage

// File: rtl/posit_unpack_if.sv
// Input word handshake plus decoded-field output handshake of the posit unpacker.
interface posit_unpack_if
  import posit_unpack_pkg::*;
#(
  parameter int unsigned N = 8
);

  logic                      in_valid;
  logic                      in_ready;
  logic [N-1:0]              in_word;
  logic                      out_valid;
  logic                      out_ready;
  logic                      sign;
  logic signed [FIELD_W-1:0] regime;
  logic signed [FIELD_W-1:0] exponent;
  logic        [FIELD_W-1:0] mantissa;
  logic                      is_zero;
  logic                      is_nar;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, sign, regime, exponent, mantissa, is_zero, is_nar
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, sign, regime, exponent, mantissa, is_zero, is_nar
  );

endinterface

// File: rtl/two_comp.sv
// Combinational two's complement negation of a W-bit word.
module two_comp #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_a,
  output logic [W-1:0] o_neg_c
);

  assign o_neg_c = ~i_a + W'(1);

endmodule

// File: rtl/posit_unpack.sv
// Serial posit<N,ES> unpacker: scans the regime run one bit per clock and
// emits sign/regime/exponent/mantissa with valid/ready on both sides.
module posit_unpack
  import posit_unpack_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned ES = 1
) (
  input  logic          clk,
  input  logic          rst,
  posit_unpack_if.slave bus
);

  localparam int unsigned SW = N - 1;
  localparam int unsigned TW = SW + FIELD_W;

  state_t              r_state, w_state_nxt;
  logic [SW-1:0]       r_sr, w_sr_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_run_bit, w_run_bit_nxt;
  posit_fields_t       r_fields, w_fields_nxt;
  logic                r_out_valid;
  logic                r_in_ready;

  logic [N-1:0]        w_neg;
  logic [N-1:0]        w_mag;
  logic                w_accept;
  logic                w_special;
  logic                w_is_nar;
  logic                w_is_run;
  logic                w_last;
  logic                w_finish;
  logic [CNT_W-1:0]    w_r_final;
  logic [SW-1:0]       w_sr_sh;
  logic [TW-1:0]       w_tail;
  logic [FIELD_W-1:0]  w_k;

  two_comp #(.W(N)) u_two_comp (
    .i_a     (bus.in_word),
    .o_neg_c (w_neg)
  );

  // Zero and NaR are the only words whose low N-1 magnitude bits are all zero
  assign w_mag     = bus.in_word[N-1] ? w_neg : bus.in_word;
  assign w_accept  = bus.in_valid && r_in_ready;
  assign w_special = (w_mag[N-2:0] == '0);
  assign w_is_nar  = w_special && w_mag[N-1];

  // The final word bit is counted into the run even when it differs,
  // so the regime spans -(N-1)..N-2
  assign w_is_run  = (r_sr[SW-1] == r_run_bit);
  assign w_last    = (r_cnt == CNT_W'(N - 2));
  assign w_finish  = !w_is_run || w_last;
  assign w_r_final = (w_is_run || w_last) ? (r_cnt + CNT_W'(1)) : r_cnt;
  assign w_sr_sh   = r_sr << 1;
  assign w_tail    = {w_sr_sh, {FIELD_W{1'b0}}};
  assign w_k       = FIELD_W'(w_r_final);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept)      w_state_nxt = w_special ? ST_OUT : ST_SCAN;
      ST_SCAN: if (w_finish)      w_state_nxt = ST_OUT;
      ST_OUT:  if (bus.out_ready) w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath next values: load on accept, shift/count while scanning
  always_comb begin
    w_sr_nxt      = r_sr;
    w_cnt_nxt     = r_cnt;
    w_run_bit_nxt = r_run_bit;
    w_fields_nxt  = r_fields;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_fields_nxt      = '0;
          w_fields_nxt.sign = bus.in_word[N-1];
          w_sr_nxt          = w_mag[SW-1:0];
          w_run_bit_nxt     = w_mag[N-2];
          w_cnt_nxt         = '0;
          if (w_special) begin
            w_fields_nxt.is_zero = !w_is_nar;
            w_fields_nxt.is_nar  = w_is_nar;
            w_fields_nxt.regime  = POSIT_SPECIAL_REGIME;
          end
        end
      end
      ST_SCAN: begin
        w_sr_nxt  = w_sr_sh;
        w_cnt_nxt = w_r_final;
        if (w_finish) begin
          w_fields_nxt.regime   = r_run_bit ? (w_k - FIELD_W'(1)) : (FIELD_W'(0) - w_k);
          w_fields_nxt.exponent = FIELD_W'(w_tail >> (TW - ES));
          w_fields_nxt.mantissa = FIELD_W'((w_tail << ES) >> SW);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr        <= '0;
      r_cnt       <= '0;
      r_run_bit   <= 1'b0;
      r_fields    <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_sr        <= w_sr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_run_bit   <= w_run_bit_nxt;
      r_fields    <= w_fields_nxt;
      r_out_valid <= (w_state_nxt == ST_OUT);
      r_in_ready  <= (w_state_nxt == ST_IDLE);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sign      = r_fields.sign;
  assign bus.regime    = r_fields.regime;
  assign bus.exponent  = r_fields.exponent;
  assign bus.mantissa  = r_fields.mantissa;
  assign bus.is_zero   = r_fields.is_zero;
  assign bus.is_nar    = r_fields.is_nar;

endmodule
